// File: rtl/seq_add_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Sizing helpers are evaluated at elaboration time from the top-level parameters.
package seq_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned digit_count(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // The counter is never narrower than one bit, even when a single digit covers the word.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned digit);
        return (digit != 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_add_sub_digit.sv
// Combinational DIGIT-bit ripple-carry adder; also exposes the carry into
// the top bit so the caller can derive signed overflow on the last digit.
module digit_adder #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (c[i] & (a[i] ^ b[i])) | (a[i] & b[i]);
        end
    end

    assign c_out = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per RUN cycle, result
// and flags held in DONE until the consumer takes them.
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = digit_count(WIDTH, DIGIT);
    localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_check
        $error("seq_add_sub: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_sh, b_sh, r_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last;

    logic [DIGIT-1:0]       d_sum;
    logic                   d_cout, d_cmsb;
    logic [WIDTH+DIGIT-1:0] r_cat;
    logic [WIDTH-1:0]       r_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .c_in  (carry),
        .sum   (d_sum),
        .c_out (d_cout),
        .c_msb (d_cmsb)
    );

    // Digits enter from the MSB side; concatenate-then-slice also covers DIGIT == WIDTH.
    assign r_cat  = {d_sum, r_sh};
    assign r_next = r_cat[WIDTH+DIGIT-1:DIGIT];
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction folds into addition: a + ~b + ~c_in.
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= c_in ^ sub;
                        r_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    r_sh  <= r_next;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        s     <= r_next;
                        c_out <= d_cout;
                        ovf   <= d_cmsb ^ d_cout;
                        zero  <= (r_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub in three configurations (16/4, 16/16, 32/8).
// Expected results come from a plain-integer arithmetic model of add/sub and flags.
module tb_seq_add_sub;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in = '0, b_in = '0;
    logic        sub_in = 1'b0, cin_in = 1'b0;
    logic [2:0]  iv = '0, ordy = '0;
    logic [2:0]  ir, ov, cv, vv, zv;
    logic [31:0] sv [3];

    logic [15:0] s0, s1;
    logic [31:0] s2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    res_t        expv [3];
    logic [2:0]  pend = '0;
    int unsigned wv [3] = '{16, 16, 32};
    int unsigned nl [3] = '{4, 1, 4};

    always #5 clk = ~clk;

    seq_add_sub #(.WIDTH(16), .DIGIT(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .sub(sub_in), .c_in(cin_in),
        .a(a_in[15:0]), .b(b_in[15:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .s(s0), .c_out(cv[0]), .ovf(vv[0]), .zero(zv[0])
    );

    seq_add_sub #(.WIDTH(16), .DIGIT(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .sub(sub_in), .c_in(cin_in),
        .a(a_in[15:0]), .b(b_in[15:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .s(s1), .c_out(cv[1]), .ovf(vv[1]), .zero(zv[1])
    );

    seq_add_sub #(.WIDTH(32), .DIGIT(8)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .sub(sub_in), .c_in(cin_in),
        .a(a_in), .b(b_in), .out_valid(ov[2]), .out_ready(ordy[2]),
        .s(s2), .c_out(cv[2]), .ovf(vv[2]), .zero(zv[2])
    );

    assign sv[0] = {16'h0, s0};
    assign sv[1] = {16'h0, s1};
    assign sv[2] = s2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the operands, signed range test for overflow.
    function automatic res_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input logic su, input logic ci);
        res_t   r;
        longint m, aa, bb, sa, sb, cl, u, sr;
        m  = longint'(1) << w;
        aa = longint'(a) & (m - 1);
        bb = longint'(b) & (m - 1);
        sa = (aa >= m / 2) ? aa - m : aa;
        sb = (bb >= m / 2) ? bb - m : bb;
        cl = ci ? 1 : 0;
        if (!su) begin
            u   = aa + bb + cl;
            sr  = sa + sb + cl;
            r.c = (u >= m);
        end else begin
            u   = aa - bb - cl;
            sr  = sa - sb - cl;
            r.c = (aa >= bb + cl);
        end
        r.s = 32'(u & (m - 1));
        r.z = ((u & (m - 1)) == 0);
        r.v = (sr >= m / 2) || (sr < -(m / 2));
        return r;
    endfunction

    // Single compare process: every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) begin
                    check($sformatf("pending%0d", i), 64'(pend[i]), 64'd1);
                    check($sformatf("s%0d", i), 64'(sv[i]), 64'(expv[i].s));
                    check($sformatf("c_out%0d", i), 64'(cv[i]), 64'(expv[i].c));
                    check($sformatf("ovf%0d", i), 64'(vv[i]), 64'(expv[i].v));
                    check($sformatf("zero%0d", i), 64'(zv[i]), 64'(expv[i].z));
                    check($sformatf("in_ready_done%0d", i), 64'(ir[i]), 64'd0);
                end
            end
        end
    end

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic su, input logic ci, input int hold);
        int n;
        @(negedge clk);
        a_in = a; b_in = b; sub_in = su; cin_in = ci;
        iv[sel] = 1'b1;
        n = 0;
        while (!ir[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 64'(ir[sel]), 64'd1);
        @(posedge clk);
        expv[sel] = model(wv[sel], a, b, su, ci);
        pend[sel] = 1'b1;
        #1;
        iv[sel] = 1'b0;
        a_in = ~a; b_in = $urandom; sub_in = ~su; cin_in = ~ci;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ov[sel] && n < 40);
        check("latency", 64'(n), 64'(nl[sel]));
        repeat (hold) begin
            @(negedge clk);
            iv[sel] = ~iv[sel];
            a_in = $urandom;
        end
        @(negedge clk);
        iv[sel] = 1'b0;
        ordy[sel] = 1'b1;
        @(posedge clk);
        pend[sel] = 1'b0;
        #1;
        ordy[sel] = 1'b0;
        check("out_valid_drop", 64'(ov[sel]), 64'd0);
        check("in_ready_after", 64'(ir[sel]), 64'd1);
    endtask

    task automatic pin(input string name, input int sel, input logic [31:0] es,
                       input logic ec, input logic ev, input logic ez);
        check({name, "_s"}, 64'(sv[sel]), 64'(es));
        check({name, "_c"}, 64'(cv[sel]), 64'(ec));
        check({name, "_v"}, 64'(vv[sel]), 64'(ev));
        check({name, "_z"}, 64'(zv[sel]), 64'(ez));
    endtask

    initial begin
        #1;
        for (int i = 0; i < 3; i++) begin
            pin("reset", i, 32'h0, 1'b0, 1'b0, 1'b0);
            check("reset_ov", 64'(ov[i]), 64'd0);
            check("reset_ir", 64'(ir[i]), 64'd1);
        end
        #12 rst = 1'b0;

        run_op(0, 32'h1234, 32'h0FFF, 1'b0, 1'b0, 0);
        pin("add", 0, 32'h2233, 1'b0, 1'b0, 1'b0);
        run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 0);
        pin("ovf", 0, 32'h8000, 1'b0, 1'b1, 1'b0);
        run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 0);
        pin("wrap", 0, 32'h0000, 1'b1, 1'b0, 1'b1);
        run_op(0, 32'h0005, 32'h0007, 1'b1, 1'b0, 0);
        pin("sub_neg", 0, 32'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(0, 32'h8000, 32'h0001, 1'b1, 1'b0, 0);
        pin("sub_ovf", 0, 32'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op(0, 32'h0010, 32'h0001, 1'b1, 1'b1, 0);
        pin("sub_bin", 0, 32'h000E, 1'b1, 1'b0, 1'b0);

        run_op(0, 32'hA5A5, 32'h1111, 1'b0, 1'b1, 5);
        pin("bp", 0, 32'hB6B7, 1'b0, 1'b0, 1'b0);
        run_op(0, 32'h0100, 32'h0200, 1'b1, 1'b0, 0);
        pin("bp_next", 0, 32'hFF00, 1'b0, 1'b0, 1'b0);

        // Abort mid-RUN: outputs must clear as soon as reset rises.
        @(negedge clk);
        a_in = 32'h00AB; b_in = 32'h0001; sub_in = 1'b0; cin_in = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        pin("abort", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("abort_ov", 64'(ov[0]), 64'd0);
        check("abort_ir", 64'(ir[0]), 64'd1);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_result", 64'(ov[0]), 64'd0);
        run_op(0, 32'h0001, 32'h0001, 1'b0, 1'b0, 0);
        pin("post_rst", 0, 32'h0002, 1'b0, 1'b0, 1'b0);

        run_op(1, 32'h1234, 32'h0FFF, 1'b0, 1'b0, 0);
        pin("d16_add", 1, 32'h2233, 1'b0, 1'b0, 1'b0);
        run_op(1, 32'h8000, 32'h0001, 1'b1, 1'b0, 2);
        pin("d16_sub", 1, 32'h7FFF, 1'b1, 1'b1, 1'b0);

        run_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        pin("w32_ovf", 2, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            run_op(2, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), k % 3);
        end
        for (int k = 0; k < 6; k++) begin
            run_op(k % 2, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
